// File: rtl/memory_pkg.sv
// Shared definitions for the data memory subsystem.
//   DATA_MEM_SIZE_BYTES : size of the data memory; legal byte addresses are [0, size)
//   ARB_PORTS           : number of requesters sharing the data memory
//   mem_req_t           : one requester's access (write flag, byte enables, address, data)
//   pend_t              : single-slot record of the response owed for the next cycle
//   addr_in_range       : range check used by the arbiter before touching memory
package memory_pkg;

    localparam int unsigned DATA_MEM_SIZE_BYTES = 4096;
    localparam int unsigned ARB_PORTS           = 2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } pend_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter for the data memory port.
// Ports:
//   clk    : clock, state updates on the rising edge
//   rst_n  : synchronous active-low reset; also suppresses all grants while low
//   req    : {req1, req0} request levels
//   ready  : memory can accept an access this cycle; 0 blocks every grant
//   gnt    : one-hot (or zero) combinational grant, same cycle as req
// With FIXED_PRIO=1 port 0 always wins; otherwise prio_q names the preferred
// port and flips to the other port after every grant.
module rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       ready,
    output logic [1:0] gnt
);

    logic prio_q;

    // prio_q only matters when both ports request at once in round-robin mode.
    always_comb begin
        gnt = 2'b00;
        if (rst_n && ready) begin
            if (FIXED_PRIO) begin
                if (req[0]) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end
            end else begin
                case (req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                    default: gnt = 2'b00;
                endcase
            end
        end
    end

    // After serving port k, the other port becomes preferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between port 0 (core LSU) and port 1
// (debug/DMA). Grants are same-cycle; read data comes back one cycle after
// the grant and is steered only to the port that issued the read. Accesses
// outside [0, MEM_SIZE_BYTES) are granted but never reach memory; they get an
// error response instead.
// Ports:
//   clk_i, rst_ni                : clock and synchronous active-low reset
//   mN_req/we/be/addr/wdata_i    : port N request (N = 0, 1), held until granted
//   mN_gnt_o                     : port N accepted this cycle
//   mN_rvalid/err/rdata_o        : port N response (reads and errored accesses)
//   mem_req/we/be/addr/wdata_o   : access towards data_mem
//   mem_rdata_i                  : read data from data_mem, one cycle after request
//   mem_ready_i                  : data_mem can accept; 0 blocks all grants
module data_mem_arbiter
    import memory_pkg::*;
#(
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter int unsigned MEM_SIZE_BYTES = DATA_MEM_SIZE_BYTES
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE_BYTES);

    logic [ARB_PORTS-1:0] gnt;
    logic                 any_gnt;
    logic                 in_range;
    mem_req_t             m0_req;
    mem_req_t             m1_req;
    mem_req_t             sel_req;
    pend_t                pend_q;

    assign m0_req = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m1_req = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .req   ({m1_req_i, m0_req_i}),
        .ready (mem_ready_i),
        .gnt   (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign any_gnt  = |gnt;

    assign sel_req  = gnt[1] ? m1_req : m0_req;
    assign in_range = addr_in_range(sel_req.addr, MEM_LIMIT);

    // Memory side sees only granted, in-range accesses; everything else is
    // driven to zero so an out-of-range write can never reach the array.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (any_gnt && in_range) begin
            mem_req_o   = 1'b1;
            mem_we_o    = sel_req.we;
            mem_be_o    = sel_req.be;
            mem_addr_o  = sel_req.addr;
            mem_wdata_o = sel_req.wdata;
        end
    end

    // One response slot is enough: every response is due exactly one cycle
    // after its grant, so the slot is rewritten every cycle. In-range writes
    // owe no response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q <= '{valid: 1'b0, port: 1'b0, err: 1'b0};
        end else begin
            pend_q.valid <= any_gnt && (!sel_req.we || !in_range);
            pend_q.port  <= gnt[1];
            pend_q.err   <= any_gnt && !in_range;
        end
    end

    // Read data is shown only to the port that owns the response, and never
    // on an error response.
    always_comb begin
        m0_rvalid_o = pend_q.valid && !pend_q.port;
        m1_rvalid_o = pend_q.valid &&  pend_q.port;
        m0_err_o    = m0_rvalid_o && pend_q.err;
        m1_err_o    = m1_rvalid_o && pend_q.err;
        m0_rdata_o  = (m0_rvalid_o && !pend_q.err) ? mem_rdata_i : 32'h0;
        m1_rdata_o  = (m1_rvalid_o && !pend_q.err) ? mem_rdata_i : 32'h0;
    end

endmodule
